// File: rtl/dot_field_generator.sv
// Dot-field generator: optional frame clear, then NUM_DOTS pseudo-random visible dots,
// each plotted to the VGA port and recorded in the dot store.
module dot_field_generator #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned COLOUR_W = 3,
    parameter int unsigned NUM_DOTS = 128,
    parameter int unsigned IDX_W    = 7
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                clear_en,
    input  logic [COLOUR_W-1:0] clear_colour,
    input  logic                seed_load,
    input  logic [15:0]         seed,
    output logic [X_W-1:0]      plot_x,
    output logic [Y_W-1:0]      plot_y,
    output logic [COLOUR_W-1:0] plot_colour,
    output logic                plot_en,
    output logic                dot_wr_en,
    output logic [IDX_W-1:0]    dot_wr_addr,
    output logic                busy,
    output logic                done
);

    localparam logic [15:0]      LFSR_INIT = 16'hACE1;
    localparam logic [X_W-1:0]   X_LAST    = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(SCREEN_H - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOTS - 1);
    localparam bit               ONE_PIXEL = (SCREEN_W * SCREEN_H == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DOTS,
        S_DONE
    } state_t;

    state_t              r_state, w_state;
    logic [15:0]         r_lfsr, w_lfsr;
    logic [IDX_W-1:0]    r_idx, w_idx;
    logic [COLOUR_W-1:0] r_clear_colour, w_clear_colour;
    logic [X_W-1:0]      r_plot_x, w_plot_x;
    logic [Y_W-1:0]      r_plot_y, w_plot_y;
    logic [COLOUR_W-1:0] r_plot_colour, w_plot_colour;
    logic                r_plot_en, w_plot_en;
    logic                r_dot_wr_en, w_dot_wr_en;
    logic [IDX_W-1:0]    r_dot_wr_addr, w_dot_wr_addr;
    logic                r_busy, w_busy;
    logic                r_done, w_done;

    logic [X_W-1:0]      w_cx, w_nx;
    logic [Y_W-1:0]      w_cy, w_ny;
    logic [COLOUR_W-1:0] w_cc;
    logic                w_accept;

    // Candidate dot and raster successor of the last cleared pixel
    always_comb begin
        w_cx     = r_lfsr[X_W-1:0];
        w_cy     = r_lfsr[X_W+Y_W-1:X_W];
        w_cc     = r_lfsr[15 -: COLOUR_W];
        w_accept = (32'(w_cx) < SCREEN_W) && (32'(w_cy) < SCREEN_H) && (w_cc != r_clear_colour);
        if (r_plot_x == X_LAST) begin
            w_nx = '0;
            w_ny = r_plot_y + Y_W'(1);
        end else begin
            w_nx = r_plot_x + X_W'(1);
            w_ny = r_plot_y;
        end
    end

    always_comb begin
        w_state        = r_state;
        w_idx          = r_idx;
        w_clear_colour = r_clear_colour;
        w_plot_x       = r_plot_x;
        w_plot_y       = r_plot_y;
        w_plot_colour  = r_plot_colour;
        w_plot_en      = 1'b0;
        w_dot_wr_en    = 1'b0;
        w_dot_wr_addr  = r_dot_wr_addr;
        w_busy         = r_busy;
        w_done         = r_done;

        // Seed load wins over stepping; a zero seed would lock the LFSR
        if (seed_load) begin
            w_lfsr = (seed == 16'h0000) ? LFSR_INIT : seed;
        end else begin
            w_lfsr = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end

        case (r_state)
            S_IDLE, S_DONE: begin
                if (r_state == S_DONE) begin
                    w_busy = 1'b0;
                    w_done = 1'b1;
                end
                if (start) begin
                    w_clear_colour = clear_colour;
                    w_idx          = '0;
                    w_busy         = 1'b1;
                    w_done         = 1'b0;
                    if (clear_en) begin
                        // First clear pixel goes out on the accepting edge
                        w_plot_x      = '0;
                        w_plot_y      = '0;
                        w_plot_colour = clear_colour;
                        w_plot_en     = 1'b1;
                        w_state       = ONE_PIXEL ? S_DOTS : S_CLEAR;
                    end else begin
                        w_state = S_DOTS;
                    end
                end
            end
            S_CLEAR: begin
                w_plot_x      = w_nx;
                w_plot_y      = w_ny;
                w_plot_colour = r_clear_colour;
                w_plot_en     = 1'b1;
                if (w_nx == X_LAST && w_ny == Y_LAST) begin
                    w_state = S_DOTS;
                end
            end
            S_DOTS: begin
                if (w_accept) begin
                    w_plot_x      = w_cx;
                    w_plot_y      = w_cy;
                    w_plot_colour = w_cc;
                    w_plot_en     = 1'b1;
                    w_dot_wr_en   = 1'b1;
                    w_dot_wr_addr = r_idx;
                    w_idx         = r_idx + IDX_W'(1);
                    if (r_idx == IDX_LAST) begin
                        w_state = S_DONE;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_lfsr         <= LFSR_INIT;
            r_idx          <= '0;
            r_clear_colour <= '0;
            r_plot_x       <= '0;
            r_plot_y       <= '0;
            r_plot_colour  <= '0;
            r_plot_en      <= 1'b0;
            r_dot_wr_en    <= 1'b0;
            r_dot_wr_addr  <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_lfsr         <= w_lfsr;
            r_idx          <= w_idx;
            r_clear_colour <= w_clear_colour;
            r_plot_x       <= w_plot_x;
            r_plot_y       <= w_plot_y;
            r_plot_colour  <= w_plot_colour;
            r_plot_en      <= w_plot_en;
            r_dot_wr_en    <= w_dot_wr_en;
            r_dot_wr_addr  <= w_dot_wr_addr;
            r_busy         <= w_busy;
            r_done         <= w_done;
        end
    end

    assign plot_x      = r_plot_x;
    assign plot_y      = r_plot_y;
    assign plot_colour = r_plot_colour;
    assign plot_en     = r_plot_en;
    assign dot_wr_en   = r_dot_wr_en;
    assign dot_wr_addr = r_dot_wr_addr;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
